iob_vexriscv_bus_adapter: RTL and testbench



---
 rtl/iob_vexriscv_bus_adapter.sv | 133 +++++++++++++
 tb/tb_iob_vexriscv_bus_adapter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_vexriscv_bus_adapter.sv
// VexRiscv simple-bus to IOb native adapter: one-entry request stage,
// strobe generation, outstanding-read limit, address remap, misalign errors.
module iob_vexriscv_bus_adapter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MODE       = 0,
  parameter int MAX_OUT    = 2,
  parameter int USE_EXTMEM = 0,
  parameter int E_BIT      = ADDR_W - 2,
  parameter int P_BIT      = ADDR_W - 3,
  parameter int MIS_ERR    = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                boot,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_wr,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_data,
  input  logic [1:0]          cmd_size,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_error,
  output logic                misalign,
  output logic                iob_valid,
  output logic [ADDR_W-1:0]   iob_addr,
  output logic [DATA_W-1:0]   iob_wdata,
  output logic [DATA_W/8-1:0] iob_wstrb,
  input  logic                iob_ready,
  input  logic                iob_rvalid,
  input  logic [DATA_W-1:0]   iob_rdata
);

  localparam int SW = DATA_W / 8;
  localparam int OW = (SW > 1) ? $clog2(SW) : 1;
  localparam int CW = 4;

  logic              hold_valid;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_wdata;
  logic [SW-1:0]     hold_wstrb;
  logic [CW-1:0]     cnt;
  logic              err_pend;

  logic              is_wr;
  logic              is_mis;
  logic              rsp_ok;
  logic              credit;
  logic              acc_al;
  logic              acc_mis;
  logic [SW-1:0]     base;
  logic [SW-1:0]     strb;
  logic [ADDR_W-1:0] addr_map;

  always_comb begin
    is_wr  = (MODE == 0) && cmd_wr;
    is_mis = 1'b0;
    if (MIS_ERR != 0 && MODE == 0) begin
      if (cmd_size == 2'd1)
        is_mis = cmd_addr[0];
      else if (cmd_size[1])
        is_mis = |cmd_addr[1:0];
    end

    rsp_ok = iob_rvalid && (cnt != '0);
    // a read answered this cycle frees a slot for a read accepted now
    credit = (cnt < CW'(MAX_OUT)) || rsp_ok;

    if (is_mis)
      cmd_ready = !hold_valid && (cnt == '0) && !err_pend;
    else
      cmd_ready = (!hold_valid || iob_ready) && credit;

    acc_al  = cmd_valid && cmd_ready && !is_mis;
    acc_mis = cmd_valid && cmd_ready && is_mis;

    unique case (1'b1)
      cmd_size == 2'd0: base = SW'(1);
      cmd_size == 2'd1: base = SW'(3);
      default:          base = '1;
    endcase
    strb = is_wr ? SW'(base << cmd_addr[OW-1:0]) : '0;

    addr_map = cmd_addr;
    if (USE_EXTMEM != 0) begin
      if (MODE == 1)
        addr_map[ADDR_W-1] = !boot;
      else
        addr_map[ADDR_W-1] = !(cmd_addr[E_BIT] ^ boot) && !cmd_addr[P_BIT];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_addr  <= '0;
      hold_wdata <= '0;
      hold_wstrb <= '0;
      cnt        <= '0;
      err_pend   <= 1'b0;
      misalign   <= 1'b0;
    end else begin
      if (acc_al) begin
        hold_valid <= 1'b1;
        hold_addr  <= addr_map;
        hold_wdata <= cmd_data;
        hold_wstrb <= strb;
      end else if (iob_ready) begin
        hold_valid <= 1'b0;
      end

      unique case ({acc_al && !is_wr, rsp_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase

      misalign <= acc_mis;
      err_pend <= acc_mis && !is_wr;
    end
  end

  assign iob_valid = hold_valid;
  assign iob_addr  = hold_addr;
  assign iob_wdata = hold_wdata;
  assign iob_wstrb = hold_wstrb;

  assign rsp_valid = err_pend || rsp_ok;
  assign rsp_error = err_pend;
  assign rsp_data  = rsp_ok ? iob_rdata : '0;

endmodule

// File: tb/tb_iob_vexriscv_bus_adapter.sv
// Bench for iob_vexriscv_bus_adapter: directed cases plus random traffic
// checked every cycle against a behavioural model of the adapter.
module tb_iob_vexriscv_bus_adapter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        boot = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_wr = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic [1:0]  cmd_size = '0;
  logic        iob_ready = 1'b0;
  logic        iob_rvalid = 1'b0;
  logic [31:0] iob_rdata = '0;

  logic        cmd_ready, rsp_valid, rsp_error, misalign, iob_valid;
  logic [31:0] rsp_data, iob_addr, iob_wdata;
  logic [3:0]  iob_wstrb;

  logic        i_cmd_ready, i_rsp_valid, i_rsp_error, i_misalign, i_iob_valid;
  logic [31:0] i_rsp_data, i_iob_addr, i_iob_wdata;
  logic [3:0]  i_iob_wstrb;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  iob_vexriscv_bus_adapter #(
    .MODE(0), .MAX_OUT(2), .USE_EXTMEM(1)
  ) dut (
    .clk(clk), .rst(rst), .boot(boot),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_size(cmd_size),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .misalign(misalign), .iob_valid(iob_valid), .iob_addr(iob_addr),
    .iob_wdata(iob_wdata), .iob_wstrb(iob_wstrb), .iob_ready(iob_ready),
    .iob_rvalid(iob_rvalid), .iob_rdata(iob_rdata)
  );

  iob_vexriscv_bus_adapter #(
    .MODE(1), .MAX_OUT(2), .USE_EXTMEM(1)
  ) idut (
    .clk(clk), .rst(rst), .boot(boot),
    .cmd_valid(cmd_valid), .cmd_ready(i_cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_size(cmd_size),
    .rsp_valid(i_rsp_valid), .rsp_data(i_rsp_data),
    .rsp_error(i_rsp_error), .misalign(i_misalign),
    .iob_valid(i_iob_valid), .iob_addr(i_iob_addr),
    .iob_wdata(i_iob_wdata), .iob_wstrb(i_iob_wstrb),
    .iob_ready(iob_ready), .iob_rvalid(iob_rvalid), .iob_rdata(iob_rdata)
  );

  // model: the pending request, reads in flight, scheduled pulses
  bit          m_hv;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  int          m_out;
  bit          m_ep, m_mis;

  logic        s_ready, s_ival, s_rv, s_rerr, s_mis, s_iival;
  logic [31:0] s_addr, s_rdata, s_iaddr;
  logic [3:0]  s_wstrb, s_iwstrb;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  function automatic bit f_mis(logic [1:0] sz, logic [31:0] a);
    if (sz == 2'd1) return a[0];
    if (sz >= 2'd2) return a[1:0] != 2'd0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] f_map(logic [31:0] a, logic b);
    logic [31:0] r;
    r = a;
    r[31] = (a[30] == b) && !a[29];
    return r;
  endfunction

  function automatic logic [3:0] f_strb(logic w, logic [1:0] sz, logic [31:0] a);
    logic [3:0] r;
    int n, off;
    r = '0;
    if (!w) return r;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    off = int'(a[1:0]);
    for (int i = 0; i < 4; i++)
      if (i >= off && i < off + n) r[i] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_hv = 0; m_out = 0; m_ep = 0; m_mis = 0;
    m_addr = '0; m_wdata = '0; m_wstrb = '0;
  endtask

  task automatic cyc(bit v, bit w, logic [31:0] a, logic [31:0] d,
                     logic [1:0] sz, bit bt, bit rdy, bit rv,
                     logic [31:0] rd);
    bit er, mis, qr, acc;
    cmd_valid = v; cmd_wr = w; cmd_addr = a; cmd_data = d;
    cmd_size = sz; boot = bt; iob_ready = rdy; iob_rvalid = rv;
    iob_rdata = rd;
    #1;
    mis = f_mis(sz, a);
    if (mis) er = !m_hv && m_out == 0 && !m_ep;
    else er = (!m_hv || rdy) && (m_out < 2 || (rv && m_out > 0));
    qr = rv && m_out > 0;
    chk("cmd_ready", 32'(cmd_ready), 32'(er));
    chk("iob_valid", 32'(iob_valid), 32'(m_hv));
    if (m_hv) begin
      chk("iob_addr", iob_addr, m_addr);
      chk("iob_wdata", iob_wdata, m_wdata);
      chk("iob_wstrb", 32'(iob_wstrb), 32'(m_wstrb));
    end
    chk("rsp_valid", 32'(rsp_valid), 32'(m_ep || qr));
    chk("rsp_error", 32'(rsp_error), 32'(m_ep));
    chk("rsp_data", rsp_data, qr ? rd : 32'h0);
    chk("misalign", 32'(misalign), 32'(m_mis));
    s_ready = cmd_ready; s_ival = iob_valid; s_addr = iob_addr;
    s_wstrb = iob_wstrb; s_rv = rsp_valid; s_rerr = rsp_error;
    s_rdata = rsp_data; s_mis = misalign; s_iival = i_iob_valid;
    s_iaddr = i_iob_addr; s_iwstrb = i_iob_wstrb;
    @(posedge clk);
    acc = v && er;
    if (acc && !mis) begin
      m_hv = 1; m_addr = f_map(a, bt); m_wdata = d;
      m_wstrb = f_strb(w, sz, a);
      if (!w) m_out++;
    end else if (rdy) begin
      m_hv = 0;
    end
    if (qr) m_out--;
    m_mis = acc && mis;
    m_ep = acc && mis && !w;
    @(negedge clk);
  endtask

  task automatic idle(bit rdy, bit rv, logic [31:0] rd);
    cyc(0, 0, 32'h0, 32'h0, 2'd2, 1, rdy, rv, rd);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_iob_valid", 32'(iob_valid), 32'd0);
    chk("rst_iob_addr", iob_addr, 32'd0);
    chk("rst_iob_wdata", iob_wdata, 32'd0);
    chk("rst_iob_wstrb", 32'(iob_wstrb), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_error", 32'(rsp_error), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    chk("rst_i_iob_valid", 32'(i_iob_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // remap, both port flavours
    cyc(1, 1, 32'h0000_0200, 32'h1122_3344, 2'd2, 0, 1, 0, 0);
    cyc(1, 1, 32'h2000_0200, 32'h5566_7788, 2'd2, 0, 1, 0, 0);
    chk("remap_d_msb1", s_addr, 32'h8000_0200);
    chk("remap_i_valid", 32'(s_iival), 32'd1);
    chk("remap_i_msb1", s_iaddr, 32'h8000_0200);
    chk("remap_i_wstrb", 32'(s_iwstrb), 32'd0);
    idle(1, 0, 0);
    chk("remap_d_pbit", s_addr, 32'h2000_0200);

    // stalled read then response
    cyc(1, 0, 32'h100, 0, 2'd2, 1, 1, 0, 0);
    chk("rd_accept", 32'(s_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      idle(0, 0, 0);
      chk("stall_valid", 32'(s_ival), 32'd1);
      chk("stall_addr", s_addr, 32'h100);
      chk("stall_ready", 32'(s_ready), 32'd0);
    end
    idle(1, 0, 0);
    chk("stall_valid4", 32'(s_ival), 32'd1);
    idle(1, 1, 32'hDEAD_BEEF);
    chk("rd_rsp_valid", 32'(s_rv), 32'd1);
    chk("rd_rsp_data", s_rdata, 32'hDEAD_BEEF);
    chk("rd_hold_clear", 32'(s_ival), 32'd0);

    // byte then half-word write, back to back
    cyc(1, 1, 32'h103, 32'hABAB_ABAB, 2'd0, 1, 1, 0, 0);
    chk("wb_ready", 32'(s_ready), 32'd1);
    cyc(1, 1, 32'h106, 32'hCDCD_CDCD, 2'd1, 1, 1, 0, 0);
    chk("wh_ready", 32'(s_ready), 32'd1);
    chk("wb_strb", 32'(s_wstrb), 32'h8);
    idle(1, 0, 0);
    chk("wh_strb", 32'(s_wstrb), 32'hC);

    // outstanding-read limit
    cyc(1, 0, 32'h10, 0, 2'd2, 1, 1, 0, 0);
    cyc(1, 0, 32'h14, 0, 2'd2, 1, 1, 0, 0);
    cyc(1, 0, 32'h18, 0, 2'd2, 1, 1, 0, 0);
    chk("max_stall1", 32'(s_ready), 32'd0);
    cyc(1, 0, 32'h18, 0, 2'd2, 1, 1, 0, 0);
    chk("max_stall2", 32'(s_ready), 32'd0);
    cyc(1, 0, 32'h18, 0, 2'd2, 1, 1, 1, 32'h0BAD_F00D);
    chk("max_release", 32'(s_ready), 32'd1);
    chk("max_rsp", 32'(s_rv), 32'd1);
    idle(1, 1, 32'h1);
    idle(1, 1, 32'h2);

    // misaligned read then misaligned write
    cyc(1, 0, 32'h102, 0, 2'd2, 1, 1, 0, 0);
    chk("mis_rd_ready", 32'(s_ready), 32'd1);
    idle(1, 0, 0);
    chk("mis_rd_noval", 32'(s_ival), 32'd0);
    chk("mis_rd_pulse", 32'(s_mis), 32'd1);
    chk("mis_rd_rsp", 32'(s_rv), 32'd1);
    chk("mis_rd_err", 32'(s_rerr), 32'd1);
    chk("mis_rd_data", s_rdata, 32'd0);
    cyc(1, 1, 32'h101, 32'h1234_1234, 2'd1, 1, 1, 0, 0);
    chk("mis_wr_ready", 32'(s_ready), 32'd1);
    idle(1, 0, 0);
    chk("mis_wr_pulse", 32'(s_mis), 32'd1);
    chk("mis_wr_norsp", 32'(s_rv), 32'd0);
    idle(1, 0, 0);

    // reset with a read outstanding
    cyc(1, 0, 32'h40, 0, 2'd2, 1, 1, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    idle(1, 1, 32'h1234_5678);
    chk("rst_spur_rsp", 32'(s_rv), 32'd0);
    chk("rst_spur_ready", 32'(s_ready), 32'd1);

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      a = $urandom();
      if ($urandom_range(0, 1) == 0) a[31:8] = '0;
      cyc($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, a,
          $urandom(), 2'($urandom_range(0, 3)),
          $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
          $urandom_range(0, 2) == 0, $urandom());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
